// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and address-map constants for the LSU memory controller.
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DMEM_RD = 2'd1,
    IO_WAIT = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  localparam logic [15:0] DMEM_BASE_HI = 16'h0000;
  localparam logic [15:0] IO_OUT_HI    = 16'h1000;
  localparam logic [15:0] IO_IN_HI     = 16'h1001;

  // Halfword lanes need an even address, a full word needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] lo, input logic [3:0] bmask);
    logic mis;
    mis = 1'b0;
    case (bmask)
      4'b0011, 4'b1100: mis = lo[0];
      4'b1111:          mis = |lo;
      default:          mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// LSU request/response handshake plus DMEM and I/O bus signals.
interface lsu_mem_ctrl_if #(
  parameter int DMEM_AW = 11
) ();
  logic               i_req;
  logic [31:0]        i_addr;
  logic               i_wren;
  logic [31:0]        i_wdata;
  logic [3:0]         i_bmask;
  logic               o_stall;
  logic               o_done;
  logic [31:0]        o_rdata;
  logic               o_err;
  logic               o_dmem_en;
  logic               o_dmem_wren;
  logic [DMEM_AW-1:0] o_dmem_addr;
  logic [31:0]        o_dmem_wdata;
  logic [3:0]         o_dmem_bmask;
  logic [31:0]        i_dmem_rdata;
  logic               o_io_req;
  logic               o_io_wren;
  logic [31:0]        o_io_addr;
  logic [31:0]        o_io_wdata;
  logic [3:0]         o_io_bmask;
  logic               i_io_ack;
  logic [31:0]        i_io_rdata;

  modport master (
    output i_req, i_addr, i_wren, i_wdata, i_bmask, i_dmem_rdata, i_io_ack, i_io_rdata,
    input  o_stall, o_done, o_rdata, o_err,
    input  o_dmem_en, o_dmem_wren, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
    input  o_io_req, o_io_wren, o_io_addr, o_io_wdata, o_io_bmask
  );

  modport slave (
    input  i_req, i_addr, i_wren, i_wdata, i_bmask, i_dmem_rdata, i_io_ack, i_io_rdata,
    output o_stall, o_done, o_rdata, o_err,
    output o_dmem_en, o_dmem_wren, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
    output o_io_req, o_io_wren, o_io_addr, o_io_wdata, o_io_bmask
  );
endinterface

// File: rtl/lsu_mem_ctrl_addr_decode.sv
// Combinational region/alignment decode of an LSU byte address.
module lsu_addr_decode
  import lsu_mem_pkg::*;
#(
  parameter int DMEM_AW = 11
) (
  input  logic [31:0] addr,
  input  logic [3:0]  bmask,
  output logic        dmem_valid,
  output logic        io_valid,
  output logic        misaligned,
  output logic        fault
);

  always_comb begin
    dmem_valid = (addr[31:16] == DMEM_BASE_HI) && ((addr[15:0] >> DMEM_AW) == 16'h0000);
    io_valid   = (addr[31:16] == IO_OUT_HI) || (addr[31:16] == IO_IN_HI);
    misaligned = is_misaligned(addr[1:0], bmask);
    fault      = ~(dmem_valid | io_valid) | misaligned;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequences LSU loads/stores onto DMEM or the I/O bus, with I/O timeout and pipeline stall.
module lsu_mem_ctrl
  import lsu_mem_pkg::*;
#(
  parameter int IO_TIMEOUT = 16,
  parameter int DMEM_AW    = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  lsu_mem_ctrl_if.slave bus
);

  localparam int CW = $clog2(IO_TIMEOUT) + 1;

  lsu_state_e    state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic dmem_valid, io_valid, misaligned, fault;
  logic accept, dmem_go, io_go, io_active, done;

  lsu_addr_decode #(.DMEM_AW(DMEM_AW)) u_decode (
    .addr       (bus.i_addr),
    .bmask      (bus.i_bmask),
    .dmem_valid (dmem_valid),
    .io_valid   (io_valid),
    .misaligned (misaligned),
    .fault      (fault)
  );

  // Accept-cycle strobes are combinational, so they are also gated by reset
  // to keep every output low while reset is held.
  always_comb begin
    accept    = (state == IDLE) && bus.i_req && i_reset;
    dmem_go   = accept && dmem_valid && !fault;
    io_go     = accept && io_valid && !fault;
    io_active = io_go || (state == IO_WAIT);
    done      = (state == RESP);

    bus.o_stall      = bus.i_req && !done && i_reset;
    bus.o_done       = done;
    bus.o_rdata      = done ? rdata_q : '0;
    bus.o_err        = done && err_q;

    bus.o_dmem_en    = dmem_go;
    bus.o_dmem_wren  = dmem_go && bus.i_wren;
    bus.o_dmem_addr  = dmem_go ? bus.i_addr[DMEM_AW-1:0] : '0;
    bus.o_dmem_wdata = dmem_go ? bus.i_wdata : '0;
    bus.o_dmem_bmask = dmem_go ? bus.i_bmask : '0;

    bus.o_io_req     = io_active;
    bus.o_io_wren    = io_active && bus.i_wren;
    bus.o_io_addr    = io_active ? bus.i_addr : '0;
    bus.o_io_wdata   = io_active ? bus.i_wdata : '0;
    bus.o_io_bmask   = io_active ? bus.i_bmask : '0;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
            if (fault) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (dmem_valid) begin
              state <= bus.i_wren ? RESP : DMEM_RD;
            end else if (bus.i_io_ack) begin
              rdata_q <= bus.i_wren ? '0 : bus.i_io_rdata;
              state   <= RESP;
            end else begin
              // The accept cycle already counts as the first request cycle.
              cnt   <= CW'(1);
              state <= IO_WAIT;
            end
          end
        end
        DMEM_RD: begin
          rdata_q <= bus.i_dmem_rdata;
          state   <= RESP;
        end
        IO_WAIT: begin
          if (bus.i_io_ack) begin
            rdata_q <= bus.i_wren ? '0 : bus.i_io_rdata;
            state   <= RESP;
          end else if (cnt == CW'(IO_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a small sync-RAM model.
module tb_lsu_mem_ctrl;
  localparam int IO_TIMEOUT = 16;
  localparam int DMEM_AW    = 11;

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_ctrl_if #(.DMEM_AW(DMEM_AW)) bus ();

  lsu_mem_ctrl #(.IO_TIMEOUT(IO_TIMEOUT), .DMEM_AW(DMEM_AW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  logic [31:0] mem [0:511];
  always @(posedge i_clk) begin
    if (bus.o_dmem_en) begin
      if (bus.o_dmem_wren) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_dmem_bmask[b]) mem[bus.o_dmem_addr[10:2]][8*b +: 8] <= bus.o_dmem_wdata[8*b +: 8];
      end else begin
        bus.i_dmem_rdata <= mem[bus.o_dmem_addr[10:2]];
      end
    end
  end

  task automatic next_cycle;
    @(posedge i_clk);
    #2;
  endtask

  task automatic start_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    bus.i_req   = 1'b1;
    bus.i_addr  = a;
    bus.i_wren  = w;
    bus.i_wdata = d;
    bus.i_bmask = m;
    #1;
  endtask

  task automatic end_req;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_wren  = 1'b0;
    bus.i_wdata = '0;
    bus.i_bmask = '0;
  endtask

  task automatic test_reset;
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_err !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got done=%b stall=%b err=%b want 0/0/0", bus.o_done, bus.o_stall, bus.o_err); end
    n_cmp++; if (bus.o_dmem_en !== 1'b0 || bus.o_io_req !== 1'b0 || bus.o_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_bus: got en=%b ioreq=%b rdata=%h want 0/0/0", bus.o_dmem_en, bus.o_io_req, bus.o_rdata); end
    i_reset = 1'b1;
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b0 || bus.o_dmem_en !== 1'b0 || bus.o_io_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got done=%b en=%b ioreq=%b want 0/0/0", bus.o_done, bus.o_dmem_en, bus.o_io_req); end
  endtask

  task automatic test_dmem_store;
    start_req(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    n_cmp++; if (bus.o_dmem_en !== 1'b1 || bus.o_dmem_wren !== 1'b1 || bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL st_c0_strobe: got en=%b wren=%b stall=%b want 1/1/1", bus.o_dmem_en, bus.o_dmem_wren, bus.o_stall); end
    n_cmp++; if (bus.o_dmem_addr !== 11'h010 || bus.o_dmem_wdata !== 32'hDEAD_BEEF || bus.o_dmem_bmask !== 4'hF) begin n_fail++; $display("FAIL st_c0_payload: got addr=%h wdata=%h bm=%h want 010/deadbeef/f", bus.o_dmem_addr, bus.o_dmem_wdata, bus.o_dmem_bmask); end
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== 32'h0 || bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL st_c1_done: got done=%b err=%b rdata=%h stall=%b want 1/0/0/0", bus.o_done, bus.o_err, bus.o_rdata, bus.o_stall); end
    n_cmp++; if (bus.o_dmem_en !== 1'b0) begin n_fail++; $display("FAIL st_c1_en: got %b want 0", bus.o_dmem_en); end
    end_req;
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL st_pulse: got done=%b want 0", bus.o_done); end
  endtask

  task automatic test_dmem_load;
    start_req(32'h0000_0010, 1'b0, 32'h0, 4'hF);
    n_cmp++; if (bus.o_dmem_en !== 1'b1 || bus.o_dmem_wren !== 1'b0 || bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL ld_c0: got en=%b wren=%b stall=%b want 1/0/1", bus.o_dmem_en, bus.o_dmem_wren, bus.o_stall); end
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b0 || bus.o_stall !== 1'b1 || bus.o_dmem_en !== 1'b0) begin n_fail++; $display("FAIL ld_c1: got done=%b stall=%b en=%b want 0/1/0", bus.o_done, bus.o_stall, bus.o_dmem_en); end
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_c2: got done=%b err=%b rdata=%h want 1/0/deadbeef", bus.o_done, bus.o_err, bus.o_rdata); end
    end_req;
    next_cycle;
  endtask

  task automatic test_io_load;
    start_req(32'h1001_0000, 1'b0, 32'h0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle;
      n_cmp++; if (bus.o_io_req !== 1'b1 || bus.o_io_wren !== 1'b0 || bus.o_io_addr !== 32'h1001_0000 || bus.o_done !== 1'b0) begin n_fail++; $display("FAIL io_ld_req_c%0d: got req=%b wren=%b addr=%h done=%b want 1/0/10010000/0", c, bus.o_io_req, bus.o_io_wren, bus.o_io_addr, bus.o_done); end
      if (c == 4) begin bus.i_io_ack = 1'b1; bus.i_io_rdata = 32'h0000_00A5; end
    end
    next_cycle;
    bus.i_io_ack = 1'b0; bus.i_io_rdata = '0;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== 32'h0000_00A5 || bus.o_io_req !== 1'b0) begin n_fail++; $display("FAIL io_ld_done: got done=%b err=%b rdata=%h req=%b want 1/0/000000a5/0", bus.o_done, bus.o_err, bus.o_rdata, bus.o_io_req); end
    end_req;
    next_cycle;
  endtask

  task automatic test_io_timeout;
    int high;
    int guard;
    high = 0; guard = 0;
    start_req(32'h1000_0004, 1'b1, 32'h0000_0055, 4'hF);
    n_cmp++; if (bus.o_io_wren !== 1'b1 || bus.o_io_wdata !== 32'h0000_0055 || bus.o_io_bmask !== 4'hF) begin n_fail++; $display("FAIL to_c0_payload: got wren=%b wdata=%h bm=%h want 1/00000055/f", bus.o_io_wren, bus.o_io_wdata, bus.o_io_bmask); end
    while (bus.o_done !== 1'b1 && guard < 40) begin
      if (bus.o_io_req === 1'b1) high++;
      next_cycle;
      guard++;
    end
    n_cmp++; if (guard >= 40) begin n_fail++; $display("FAIL to_bound: got no o_done in %0d cycles want done", guard); end
    n_cmp++; if (high !== IO_TIMEOUT) begin n_fail++; $display("FAIL to_req_cycles: got %0d want %0d", high, IO_TIMEOUT); end
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_rdata !== 32'h0 || bus.o_io_req !== 1'b0) begin n_fail++; $display("FAIL to_done: got err=%b rdata=%h req=%b want 1/0/0", bus.o_err, bus.o_rdata, bus.o_io_req); end
    end_req;
    next_cycle;
  endtask

  task automatic test_ack_on_timeout;
    start_req(32'h1001_0008, 1'b0, 32'h0, 4'hF);
    for (int c = 1; c < IO_TIMEOUT; c++) next_cycle;
    n_cmp++; if (bus.o_io_req !== 1'b1 || bus.o_done !== 1'b0) begin n_fail++; $display("FAIL ackto_last: got req=%b done=%b want 1/0", bus.o_io_req, bus.o_done); end
    bus.i_io_ack = 1'b1; bus.i_io_rdata = 32'h1234_5678;
    next_cycle;
    bus.i_io_ack = 1'b0; bus.i_io_rdata = '0;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ackto_done: got done=%b err=%b rdata=%h want 1/0/12345678", bus.o_done, bus.o_err, bus.o_rdata); end
    end_req;
    next_cycle;
  endtask

  task automatic test_faults;
    logic [31:0] fa [4];
    logic [3:0]  fm [4];
    fa[0] = 32'h2000_0000; fm[0] = 4'hF;
    fa[1] = 32'h0000_0802; fm[1] = 4'hF;
    fa[2] = 32'h0000_0002; fm[2] = 4'hF;
    fa[3] = 32'h1000_0001; fm[3] = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      start_req(fa[i], 1'b0, 32'h0, fm[i]);
      n_cmp++; if (bus.o_dmem_en !== 1'b0 || bus.o_io_req !== 1'b0 || bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL flt%0d_c0: got en=%b ioreq=%b stall=%b want 0/0/1", i, bus.o_dmem_en, bus.o_io_req, bus.o_stall); end
      next_cycle;
      n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b1 || bus.o_rdata !== 32'h0 || bus.o_io_req !== 1'b0) begin n_fail++; $display("FAIL flt%0d_c1: got done=%b err=%b rdata=%h ioreq=%b want 1/1/0/0", i, bus.o_done, bus.o_err, bus.o_rdata, bus.o_io_req); end
      end_req;
      next_cycle;
    end
  endtask

  task automatic test_back_to_back;
    start_req(32'h0000_0014, 1'b1, 32'h1111_2222, 4'hF);
    next_cycle;
    bus.i_addr = 32'h0000_0018; bus.i_wdata = 32'h3333_4444;
    #1;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_dmem_en !== 1'b0) begin n_fail++; $display("FAIL b2b_resp: got done=%b en=%b want 1/0", bus.o_done, bus.o_dmem_en); end
    next_cycle;
    n_cmp++; if (bus.o_dmem_en !== 1'b1 || bus.o_dmem_addr !== 11'h018 || bus.o_dmem_wdata !== 32'h3333_4444 || bus.o_done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got en=%b addr=%h wdata=%h done=%b want 1/018/33334444/0", bus.o_dmem_en, bus.o_dmem_addr, bus.o_dmem_wdata, bus.o_done); end
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got done=%b err=%b want 1/0", bus.o_done, bus.o_err); end
    end_req;
    next_cycle;
  endtask

  task automatic test_flush_and_late_ack;
    bus.i_io_ack = 1'b1; bus.i_io_rdata = 32'hFFFF_FFFF;
    next_cycle;
    bus.i_io_ack = 1'b0; bus.i_io_rdata = '0;
    n_cmp++; if (bus.o_done !== 1'b0 || bus.o_io_req !== 1'b0 || bus.o_rdata !== 32'h0) begin n_fail++; $display("FAIL late_ack: got done=%b ioreq=%b rdata=%h want 0/0/0", bus.o_done, bus.o_io_req, bus.o_rdata); end
    start_req(32'h0000_0014, 1'b0, 32'h0, 4'hF);
    next_cycle;
    bus.i_req = 1'b0;
    #1;
    n_cmp++; if (bus.o_stall !== 1'b0 || bus.o_done !== 1'b0) begin n_fail++; $display("FAIL flush_c1: got stall=%b done=%b want 0/0", bus.o_stall, bus.o_done); end
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL flush_done: got done=%b rdata=%h want 1/11112222", bus.o_done, bus.o_rdata); end
    end_req;
    next_cycle;
  endtask

  task automatic test_mid_reset;
    start_req(32'h1000_0000, 1'b0, 32'h0, 4'hF);
    next_cycle; next_cycle; next_cycle;
    n_cmp++; if (bus.o_io_req !== 1'b1) begin n_fail++; $display("FAIL mrst_pre: got ioreq=%b want 1", bus.o_io_req); end
    i_reset = 1'b0;
    #1;
    n_cmp++; if (bus.o_io_req !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_done !== 1'b0 || bus.o_dmem_en !== 1'b0 || bus.o_err !== 1'b0 || bus.o_rdata !== 32'h0 || bus.o_io_addr !== 32'h0) begin n_fail++; $display("FAIL mrst_async: got req=%b stall=%b done=%b en=%b err=%b rdata=%h ioaddr=%h want all 0", bus.o_io_req, bus.o_stall, bus.o_done, bus.o_dmem_en, bus.o_err, bus.o_rdata, bus.o_io_addr); end
    end_req;
    next_cycle;
    i_reset = 1'b1;
    next_cycle;
    start_req(32'h0000_0010, 1'b0, 32'h0, 4'hF);
    n_cmp++; if (bus.o_dmem_en !== 1'b1) begin n_fail++; $display("FAIL mrst_ld_c0: got en=%b want 1", bus.o_dmem_en); end
    next_cycle;
    next_cycle;
    n_cmp++; if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mrst_ld_done: got done=%b err=%b rdata=%h want 1/0/deadbeef", bus.o_done, bus.o_err, bus.o_rdata); end
    end_req;
    next_cycle;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b0;
    bus.i_io_ack = 1'b0;
    bus.i_io_rdata = '0;
    bus.i_dmem_rdata = '0;
    end_req;
    test_reset;
    test_dmem_store;
    test_dmem_load;
    test_io_load;
    test_io_timeout;
    test_ack_on_timeout;
    test_faults;
    test_back_to_back;
    test_flush_and_late_ack;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
